// File: rtl/fifo1_arb_pkg.sv
// rtl/fifo1_arb_pkg.sv - shared types and helpers for the Fifo1 enq arbiter
//
// Purpose: default sizes, the source-id type and a reference round-robin pick
// function for the default requester count.
package fifo1_arb_pkg;

  localparam int N_DEFAULT   = 4;
  localparam int W_DEFAULT   = 704;
  localparam int IDW_DEFAULT = $clog2(N_DEFAULT);

  typedef logic [IDW_DEFAULT-1:0] src_id_t;

  // First set bit of mask scanning ptr, ptr+1, ... with wrap; one-hot or zero.
  function automatic logic [N_DEFAULT-1:0] rr_pick(input logic [N_DEFAULT-1:0] mask,
                                                   input src_id_t ptr);
    logic [N_DEFAULT-1:0] oh;
    logic                 found;
    int                   j;
    oh    = '0;
    found = 1'b0;
    for (int k = 0; k < N_DEFAULT; k++) begin
      j = (int'(ptr) + k) % N_DEFAULT;
      if (!found && mask[j]) begin
        oh[j] = 1'b1;
        found = 1'b1;
      end
    end
    return oh;
  endfunction

endpackage

// File: rtl/fifo1_enq_arbiter_pick.sv
// rtl/fifo1_enq_arbiter_pick.sv - combinational round-robin one-hot picker
//
// Purpose: returns the first set bit of mask at or after ptr (wrapping), one-hot.
// Ports:
//   mask   in  N    candidate requesters
//   ptr    in  IDW  highest-priority index this cycle (must be < N)
//   onehot out N    winner, zero when mask is zero
module rr_pick_onehot
  import fifo1_arb_pkg::*;
#(
  parameter int N   = N_DEFAULT,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   mask,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   onehot
);

  logic [N-1:0] rot;
  logic [N-1:0] rot_oh;

  always_comb begin
    // Rotate so ptr lands on bit 0, isolate the lowest set bit, rotate back.
    rot    = N'({mask, mask} >> ptr);
    rot_oh = rot & (~rot + N'(1));
    onehot = N'(({rot_oh, rot_oh} << ptr) >> N);
  end

endmodule

// File: rtl/fifo1_enq_arbiter.sv
// rtl/fifo1_enq_arbiter.sv - round-robin sharing of one Fifo1 enq port among N producers
//
// Purpose: registered one-hot grant, zero-latency payload pass-through, source tagging
// and sticky ENA-without-RDY error flags.
// Ports:
//   CLK, nRST      clock, synchronous active-low reset
//   req            per-requester pending level
//   enq__ENA/_RDY  per-requester enq handshake
//   enq_v          packed payloads, requester i at [i*W +: W]
//   dn_enq__ENA/_v shared FIFO enq strobe and payload; dn_enq__RDY its ready
//   dn_src         index of the granted requester
//   protocol_err   sticky violation flags, cleared by err_clear
module fifo1_enq_arbiter
  import fifo1_arb_pkg::*;
#(
  parameter int N   = N_DEFAULT,
  parameter int W   = W_DEFAULT,
  parameter int IDW = $clog2(N)
) (
  input  logic           CLK,
  input  logic           nRST,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   enq__ENA,
  input  logic [N*W-1:0] enq_v,
  output logic [N-1:0]   enq__RDY,
  output logic           dn_enq__ENA,
  output logic [W-1:0]   dn_enq_v,
  output logic [IDW-1:0] dn_src,
  input  logic           dn_enq__RDY,
  output logic [N-1:0]   protocol_err,
  input  logic           err_clear
);

  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [N-1:0]   protocol_err_q, protocol_err_d;

  logic [N-1:0]   fire;
  logic           fire_any;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] idx_inc;
  logic [N-1:0]   pick_mask;
  logic [IDW-1:0] pick_ptr;
  logic [N-1:0]   pick_oh;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_q[i]) gnt_idx = IDW'(i);
    end
  end

  always_comb begin
    dn_enq_v = '0;
    for (int i = 0; i < N; i++) begin
      dn_enq_v = dn_enq_v | (enq_v[i*W +: W] & {W{gnt_q[i]}});
    end
  end

  always_comb begin
    // Gated by nRST so nothing is offered or forwarded in the reset cycle.
    enq__RDY    = nRST ? (gnt_q & {N{dn_enq__RDY}}) : '0;
    fire        = enq__ENA & enq__RDY;
    fire_any    = |fire;
    dn_enq__ENA = fire_any;
    dn_src      = (nRST && (|gnt_q)) ? gnt_idx : '0;
    idx_inc     = (gnt_idx == IDW'(N - 1)) ? '0 : gnt_idx + IDW'(1);
    // After a transfer the winner is excluded and the search starts just past it,
    // so another pending requester is granted back-to-back.
    pick_mask   = fire_any ? (req & ~fire) : req;
    pick_ptr    = fire_any ? idx_inc : rr_ptr_q;
  end

  rr_pick_onehot #(.N(N), .IDW(IDW)) u_pick (
    .mask   (pick_mask),
    .ptr    (pick_ptr),
    .onehot (pick_oh)
  );

  always_comb begin
    gnt_d          = gnt_q;
    rr_ptr_d       = rr_ptr_q;
    protocol_err_d = err_clear ? '0 : (protocol_err_q | (enq__ENA & ~enq__RDY));
    if (gnt_q == '0) begin
      gnt_d = pick_oh;
    end else if (fire_any) begin
      gnt_d    = pick_oh;
      rr_ptr_d = idx_inc;
    end else if (|(gnt_q & ~req)) begin
      // Holder withdrew: re-arbitrate from the unchanged pointer.
      gnt_d = pick_oh;
    end
    // Otherwise the grant is held, including while the FIFO is full.
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      gnt_q          <= '0;
      rr_ptr_q       <= '0;
      protocol_err_q <= '0;
    end else begin
      gnt_q          <= gnt_d;
      rr_ptr_q       <= rr_ptr_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_fifo1_enq_arbiter.sv
// tb/tb_fifo1_enq_arbiter.sv - self-checking bench for fifo1_enq_arbiter
module tb_fifo1_enq_arbiter;
  import fifo1_arb_pkg::*;

  localparam int N   = 4;
  localparam int W   = 704;
  localparam int IDW = 2;

  typedef struct {
    logic [N-1:0]   req;
    logic [N-1:0]   ena;
    logic           drdy;
    logic           clr;
    logic           nrst;
    logic [N-1:0]   exp_rdy;
    logic           exp_ena;
    logic [IDW-1:0] exp_src;
    logic [N-1:0]   exp_err;
  } vec_t;

  typedef struct {
    logic [IDW-1:0] src;
    logic [W-1:0]   data;
  } sb_t;

  logic           CLK = 1'b0;
  logic           nRST;
  logic [N-1:0]   req, enq_ena, enq_rdy, protocol_err;
  logic [N*W-1:0] enq_v;
  logic           dn_ena, dn_rdy, err_clear;
  logic [W-1:0]   dn_v;
  logic [IDW-1:0] dn_src;
  logic [W-1:0]   pay [N];

  sb_t  sb_q[$];
  vec_t tbl[15];
  int   n_checks = 0;
  int   n_pass   = 0;

  // reference model state for the random phase
  logic [N-1:0]   m_gnt, m_err, rq, rd, en, fr;
  logic [IDW-1:0] m_ptr;
  int             m_idx;
  logic           nr, dr, cl;

  always #5 CLK = ~CLK;

  always_comb begin
    for (int i = 0; i < N; i++) enq_v[i*W +: W] = pay[i];
  end

  fifo1_enq_arbiter #(.N(N), .W(W), .IDW(IDW)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .req          (req),
    .enq__ENA     (enq_ena),
    .enq_v        (enq_v),
    .enq__RDY     (enq_rdy),
    .dn_enq__ENA  (dn_ena),
    .dn_enq_v     (dn_v),
    .dn_src       (dn_src),
    .dn_enq__RDY  (dn_rdy),
    .protocol_err (protocol_err),
    .err_clear    (err_clear)
  );

  function automatic vec_t mkv(input logic [N-1:0] rq_i, input logic [N-1:0] en_i,
                               input logic dr_i, input logic cl_i, input logic nr_i,
                               input logic [N-1:0] xr, input logic xe,
                               input logic [IDW-1:0] xs, input logic [N-1:0] xerr);
    vec_t v;
    v.req = rq_i; v.ena = en_i; v.drdy = dr_i; v.clr = cl_i; v.nrst = nr_i;
    v.exp_rdy = xr; v.exp_ena = xe; v.exp_src = xs; v.exp_err = xerr;
    return v;
  endfunction

  function automatic logic [N-1:0] m_pick(input logic [N-1:0] mask, input int p);
    for (int k = 0; k < N; k++) begin
      if (mask[(p + k) % N]) return N'(1) << ((p + k) % N);
    end
    return '0;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive one cycle of inputs just after a posedge, check at the negedge.
  task automatic apply(input vec_t v, input string tag);
    sb_t e;
    req = v.req; enq_ena = v.ena; dn_rdy = v.drdy; err_clear = v.clr; nRST = v.nrst;
    if (v.exp_ena) sb_q.push_back('{src: v.exp_src, data: pay[v.exp_src]});
    @(negedge CLK);
    chk({tag, " enq_rdy"},      W'(enq_rdy),      W'(v.exp_rdy));
    chk({tag, " dn_enq_ena"},   W'(dn_ena),       W'(v.exp_ena));
    chk({tag, " dn_src"},       W'(dn_src),       W'(v.exp_src));
    chk({tag, " protocol_err"}, W'(protocol_err), W'(v.exp_err));
    if (dn_ena === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL %s unexpected_enq: got src %0d expected no transfer", tag, dn_src);
      end else begin
        e = sb_q.pop_front();
        chk({tag, " sb_src"},  W'(dn_src), W'(e.src));
        chk({tag, " sb_data"}, dn_v,       e.data);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) pay[i] = {22{32'h1000_0000 + 32'(i)}};
    pay[2] = 704'hA5;

    // reset, release, single requester, withdraw, pointer, protocol error
    tbl[0]  = mkv(4'hF, 4'h0, 1, 0, 0, 4'h0, 0, 0, 4'h0);
    tbl[1]  = mkv(4'hF, 4'h0, 1, 0, 0, 4'h0, 0, 0, 4'h0);
    tbl[2]  = mkv(4'hF, 4'hF, 1, 0, 0, 4'h0, 0, 0, 4'h0);
    tbl[3]  = mkv(4'hF, 4'h0, 1, 0, 1, 4'h0, 0, 0, 4'h0);
    tbl[4]  = mkv(4'hF, 4'h0, 1, 0, 1, 4'h1, 0, 0, 4'h0);
    tbl[5]  = mkv(4'h4, 4'h0, 1, 0, 1, 4'h1, 0, 0, 4'h0);
    tbl[6]  = mkv(4'h4, 4'h4, 1, 0, 1, 4'h4, 1, 2, 4'h0);
    tbl[7]  = mkv(4'h0, 4'h0, 1, 0, 1, 4'h0, 0, 0, 4'h0);
    tbl[8]  = mkv(4'hF, 4'h0, 1, 0, 1, 4'h0, 0, 0, 4'h0);
    tbl[9]  = mkv(4'hF, 4'h0, 1, 0, 1, 4'h8, 0, 3, 4'h0);
    tbl[10] = mkv(4'hF, 4'h8, 1, 0, 1, 4'h8, 1, 3, 4'h0);
    tbl[11] = mkv(4'hF, 4'h8, 1, 0, 1, 4'h1, 0, 0, 4'h0);
    tbl[12] = mkv(4'hF, 4'h0, 1, 0, 1, 4'h1, 0, 0, 4'h8);
    tbl[13] = mkv(4'hF, 4'h8, 1, 1, 1, 4'h1, 0, 0, 4'h8);
    tbl[14] = mkv(4'hF, 4'h0, 1, 0, 1, 4'h1, 0, 0, 4'h0);

    nRST = 1'b0; req = 4'hF; enq_ena = '0; dn_rdy = 1'b1; err_clear = 1'b0;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 15; i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // back-to-back round robin, one transfer per cycle
    for (int k = 0; k < 8; k++)
      apply(mkv(4'hF, 4'h1 << (k % 4), 1, 0, 1, 4'h1 << (k % 4), 1, IDW'(k % 4), 4'h0),
            $sformatf("rr%0d", k));

    // FIFO-full stall on requester 1: grant held, fires when ready returns
    apply(mkv(4'hF, 4'h1, 1, 0, 1, 4'h1, 1, 0, 4'h0), "stall_pre");
    for (int k = 0; k < 5; k++)
      apply(mkv(4'hF, 4'h0, 0, 0, 1, 4'h0, 0, 1, 4'h0), $sformatf("stall%0d", k));
    apply(mkv(4'hF, 4'h2, 1, 0, 1, 4'h2, 1, 1, 4'h0), "stall_release");

    // randomized traffic against an independent model
    rq = 4'hF;
    for (int c = 0; c < 400; c++) begin
      nr = !(c == 0 || $urandom_range(0, 49) == 0);
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
      dr = ($urandom_range(0, 3) != 0);
      cl = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < N; i++) pay[i] = {22{$urandom()}};
      if (c == 0) begin
        m_gnt = '0; m_err = '0; m_ptr = '0;
      end
      rd = nr ? (m_gnt & {N{dr}}) : '0;
      en = ($urandom_range(0, 1) == 1) ? rd : '0;
      if ($urandom_range(0, 9) == 0) en = en | 4'($urandom);
      fr = en & rd;
      m_idx = 0;
      for (int i = 0; i < N; i++) if (m_gnt[i]) m_idx = i;
      apply(mkv(rq, en, dr, cl, nr, rd, |fr,
                (nr && m_gnt != 0) ? IDW'(m_idx) : '0, m_err),
            $sformatf("rand%0d", c));
      if (!nr) begin
        m_gnt = '0; m_ptr = '0; m_err = '0;
      end else begin
        m_err = cl ? '0 : (m_err | (en & ~rd));
        if (m_gnt == 0) m_gnt = m_pick(rq, int'(m_ptr));
        else if (fr != 0) begin
          m_ptr = IDW'((m_idx + 1) % N);
          m_gnt = m_pick(rq & ~fr, int'(m_ptr));
        end else if ((m_gnt & ~rq) != 0) m_gnt = m_pick(rq, int'(m_ptr));
      end
    end

    chk("scoreboard_empty", W'(sb_q.size()), W'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
